// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request port between the instruction fetch
// unit (IFU) and the load/store unit (LSU). One transaction is outstanding at
// a time, sequenced by an IDLE -> ISSUE -> WAIT FSM.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants under
// contention; when undefined the LSU always wins contention.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  // load/store port
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [2:0]  lsu_len,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  // shared memory port
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_len,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  arb_owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IFU  = 2'b01,
    OWN_LSU  = 2'b10
  } owner_e;

  state_e state, state_d;
  owner_e owner;
  logic   pick_lsu;
  logic   accept;
  logic   grant_ifu;
  logic   grant_lsu;
  logic   resp_fire;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = the most recent grant went to the LSU; reset means "last was IFU",
  // so the first contention after reset goes to the LSU.
  logic rr_last_lsu;

  // Winner selection: under contention favour whoever was not granted last.
  always_comb begin
    pick_lsu = lsu_req_valid && (!ifu_req_valid || !rr_last_lsu);
  end

  // Round-robin pointer follows every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_lsu <= 1'b0;
    end else if (grant_lsu) begin
      rr_last_lsu <= 1'b1;
    end else if (grant_ifu) begin
      rr_last_lsu <= 1'b0;
    end
  end
`else
  // Winner selection: fixed priority, the LSU wins any contention.
  always_comb begin
    pick_lsu = lsu_req_valid;
  end
`endif

  // Grant decode; reset suppresses acceptance so no ready pulses while rst=1.
  always_comb begin
    accept    = !rst && (state == ST_IDLE) && (ifu_req_valid || lsu_req_valid);
    grant_lsu = accept && pick_lsu;
    grant_ifu = accept && !pick_lsu;
    resp_fire = !rst && (state == ST_WAIT) && mem_resp_valid;
  end

  // Next-state logic and all combinational outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state;
    ifu_req_ready  = grant_ifu;
    lsu_req_ready  = grant_lsu;
    mem_req_valid  = !rst && (state == ST_ISSUE);
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = 32'h0;
    lsu_rdata      = 32'h0;

    case (state)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (resp_fire) begin
      if (owner == OWN_IFU) begin
        ifu_resp_valid = 1'b1;
        ifu_rdata      = mem_rdata;
      end else if (owner == OWN_LSU) begin
        lsu_resp_valid = 1'b1;
        lsu_rdata      = mem_rdata;
      end
    end
  end

  // FSM state, owner and latched request fields.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_NONE;
      mem_addr  <= 32'h0;
      mem_wen   <= 1'b0;
      mem_wdata <= 32'h0;
      mem_len   <= 3'd0;
    end else begin
      state <= state_d;
      if (grant_ifu) begin
        owner     <= OWN_IFU;
        mem_addr  <= ifu_addr;
        mem_wen   <= 1'b0;
        mem_wdata <= 32'h0;
        mem_len   <= 3'd4;
      end else if (grant_lsu) begin
        owner     <= OWN_LSU;
        mem_addr  <= lsu_addr;
        mem_wen   <= lsu_wen;
        mem_wdata <= lsu_wdata;
        mem_len   <= lsu_len;
      end else if (resp_fire) begin
        owner <= OWN_NONE;
      end
    end
  end

  assign arb_owner = owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change 1 time unit
// after each rising edge; outputs are compared on the falling edge.
// Contention expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic [31:0] ifu_addr;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [2:0]  lsu_len;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_len;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic [1:0]  arb_owner;

  int vectors    = 0;
  int miscompares = 0;

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_addr       (ifu_addr),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_len        (lsu_len),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_len        (mem_len),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .arb_owner      (arb_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to the next drive point (just after a rising edge).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Advance to the compare point of the current cycle.
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ifu_req_ready"},  {31'h0, ifu_req_ready},  32'h0);
    check({tag, ".lsu_req_ready"},  {31'h0, lsu_req_ready},  32'h0);
    check({tag, ".ifu_resp_valid"}, {31'h0, ifu_resp_valid}, 32'h0);
    check({tag, ".lsu_resp_valid"}, {31'h0, lsu_resp_valid}, 32'h0);
    check({tag, ".mem_req_valid"},  {31'h0, mem_req_valid},  32'h0);
    check({tag, ".arb_owner"},      {30'h0, arb_owner},      32'h0);
    check({tag, ".mem_addr"},       mem_addr,                32'h0);
    check({tag, ".mem_wdata"},      mem_wdata,               32'h0);
    check({tag, ".mem_len"},        {29'h0, mem_len},        32'h0);
    check({tag, ".mem_wen"},        {31'h0, mem_wen},        32'h0);
  endtask

  task automatic idle_inputs();
    ifu_req_valid  = 1'b0;
    ifu_addr       = 32'h0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = 32'h0;
    lsu_wen        = 1'b0;
    lsu_wdata      = 32'h0;
    lsu_len        = 3'd0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    to_sample();
    check_all_zero("reset");
    next_cycle();
    rst = 1'b0;
  endtask

  logic [1:0] exp_owner [4];

  initial begin
    rst = 1'b1;
    idle_inputs();
`ifdef ARB_ROUND_ROBIN_EN
    exp_owner = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_owner = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif

    // ---- reset state ----
    do_reset();

    // ---- IFU read at minimum latency; memory strobes held high ----
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0000;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_0413;
    to_sample();                                   // cycle 0
    check("c0.ifu_req_ready",  {31'h0, ifu_req_ready},  32'h1);
    check("c0.lsu_req_ready",  {31'h0, lsu_req_ready},  32'h0);
    check("c0.ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
    check("c0.mem_req_valid",  {31'h0, mem_req_valid},  32'h0);
    next_cycle();
    ifu_req_valid = 1'b0;                          // drop after acceptance
    ifu_addr      = 32'h0;
    to_sample();                                   // cycle 1
    check("c1.mem_req_valid",  {31'h0, mem_req_valid},  32'h1);
    check("c1.mem_addr",       mem_addr,                32'h8000_0000);
    check("c1.mem_wen",        {31'h0, mem_wen},        32'h0);
    check("c1.mem_len",        {29'h0, mem_len},        32'h4);
    check("c1.arb_owner",      {30'h0, arb_owner},      32'h1);
    check("c1.ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
    check("c1.ifu_req_ready",  {31'h0, ifu_req_ready},  32'h0);
    next_cycle();
    to_sample();                                   // cycle 2
    check("c2.ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h1);
    check("c2.ifu_rdata",      ifu_rdata,               32'h0000_0413);
    check("c2.lsu_resp_valid", {31'h0, lsu_resp_valid}, 32'h0);
    check("c2.lsu_rdata",      lsu_rdata,               32'h0);
    check("c2.mem_req_valid",  {31'h0, mem_req_valid},  32'h0);
    next_cycle();
    idle_inputs();
    to_sample();                                   // back in IDLE
    check("c3.arb_owner",      {30'h0, arb_owner},      32'h0);
    check("c3.ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);

    // ---- LSU byte store with a 3-cycle mem_req_ready stall ----
    next_cycle();
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_len       = 3'd1;
    to_sample();
    check("st.lsu_req_ready", {31'h0, lsu_req_ready}, 32'h1);
    check("st.ifu_req_ready", {31'h0, ifu_req_ready}, 32'h0);
    next_cycle();
    idle_inputs();                                 // LSU fields change after acceptance
    for (int i = 0; i < 3; i++) begin
      to_sample();
      check($sformatf("stall%0d.mem_req_valid", i), {31'h0, mem_req_valid}, 32'h1);
      check($sformatf("stall%0d.mem_addr", i),      mem_addr,               32'h8000_1000);
      check($sformatf("stall%0d.mem_wen", i),       {31'h0, mem_wen},       32'h1);
      check($sformatf("stall%0d.mem_len", i),       {29'h0, mem_len},       32'h1);
      check($sformatf("stall%0d.mem_wdata", i),     mem_wdata,              32'hDEAD_BEEF);
      check($sformatf("stall%0d.arb_owner", i),     {30'h0, arb_owner},     32'h2);
      next_cycle();
    end
    mem_req_ready = 1'b1;                          // accepted this cycle
    to_sample();
    check("st.accept.mem_req_valid", {31'h0, mem_req_valid}, 32'h1);
    check("st.accept.mem_wdata",     mem_wdata,              32'hDEAD_BEEF);
    next_cycle();
    mem_req_ready = 1'b0;
    to_sample();                                   // WAIT, no response yet
    check("st.wait.lsu_resp_valid", {31'h0, lsu_resp_valid}, 32'h0);
    check("st.wait.mem_req_valid",  {31'h0, mem_req_valid},  32'h0);
    next_cycle();
    mem_resp_valid = 1'b1;
    to_sample();
    check("st.done.lsu_resp_valid", {31'h0, lsu_resp_valid}, 32'h1);
    check("st.done.ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
    check("st.done.ifu_rdata",      ifu_rdata,               32'h0);
    next_cycle();

    // ---- spurious response in IDLE ----
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h1234_5678;
    to_sample();
    check("spur.ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
    check("spur.lsu_resp_valid", {31'h0, lsu_resp_valid}, 32'h0);
    check("spur.ifu_rdata",      ifu_rdata,               32'h0);
    check("spur.lsu_rdata",      lsu_rdata,               32'h0);
    check("spur.arb_owner",      {30'h0, arb_owner},      32'h0);
    next_cycle();
    idle_inputs();

    // ---- continuous contention, four back-to-back transactions ----
    do_reset();
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0100;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_2000;
    lsu_wen        = 1'b0;
    lsu_len        = 3'd4;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hCAFE_0000;
    for (int t = 0; t < 4; t++) begin
      to_sample();                                 // IDLE: grant
      check($sformatf("arb%0d.ifu_req_ready", t), {31'h0, ifu_req_ready}, {31'h0, exp_owner[t] == 2'b01});
      check($sformatf("arb%0d.lsu_req_ready", t), {31'h0, lsu_req_ready}, {31'h0, exp_owner[t] == 2'b10});
      next_cycle();
      to_sample();                                 // ISSUE
      check($sformatf("arb%0d.arb_owner", t), {30'h0, arb_owner}, {30'h0, exp_owner[t]});
      check($sformatf("arb%0d.mem_addr", t), mem_addr,
            (exp_owner[t] == 2'b10) ? 32'h8000_2000 : 32'h8000_0100);
      next_cycle();
      to_sample();                                 // WAIT: response
      check($sformatf("arb%0d.ifu_resp_valid", t), {31'h0, ifu_resp_valid}, {31'h0, exp_owner[t] == 2'b01});
      check($sformatf("arb%0d.lsu_resp_valid", t), {31'h0, lsu_resp_valid}, {31'h0, exp_owner[t] == 2'b10});
      next_cycle();
    end
    idle_inputs();

    // ---- reset while in WAIT, late response afterwards ----
    to_sample();
    next_cycle();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0200;
    mem_req_ready = 1'b1;
    to_sample();
    check("rw.ifu_req_ready", {31'h0, ifu_req_ready}, 32'h1);
    next_cycle();                                  // ISSUE
    ifu_req_valid = 1'b0;
    next_cycle();                                  // WAIT
    mem_req_ready = 1'b0;
    to_sample();
    check("rw.wait.mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
    check("rw.wait.arb_owner",     {30'h0, arb_owner},     32'h1);
    rst = 1'b1;
    to_sample();
    check("rw.rst.ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
    next_cycle();
    rst            = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    to_sample();
    check("rw.late.ifu_resp_valid", {31'h0, ifu_resp_valid}, 32'h0);
    check("rw.late.lsu_resp_valid", {31'h0, lsu_resp_valid}, 32'h0);
    check("rw.late.ifu_rdata",      ifu_rdata,               32'h0);
    check("rw.late.arb_owner",      {30'h0, arb_owner},      32'h0);
    check("rw.late.mem_req_valid",  {31'h0, mem_req_valid},  32'h0);
    next_cycle();
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b1;                         // only IDLE accepts
    to_sample();
    check("rw.idle.ifu_req_ready", {31'h0, ifu_req_ready}, 32'h1);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 ifu_req_valid  input  1  fetch read request pending.
REQ-005 ifu_addr  input  32  fetch address.
REQ-006 ifu_req_ready  output  1  one-cycle pulse: fetch request accepted.
REQ-007 ifu_resp_valid  output  1  one-cycle pulse: fetch data valid.
REQ-008 ifu_rdata  output  32  fetch data.
REQ-009 lsu_req_valid  input  1  load/store request pending.
REQ-010 lsu_addr  input  32  load/store address.
REQ-011 lsu_wen  input  1  1 = store, 0 = load.
REQ-012 lsu_wdata  input  32  store data.
REQ-013 lsu_len  input  3  access bytes: 1, 2 or 4.
REQ-014 lsu_req_ready  output  1  one-cycle pulse: load/store request accepted.
REQ-015 lsu_resp_valid  output  1  one-cycle pulse: load data valid or store done.
REQ-016 lsu_rdata  output  32  load data, raw 32-bit word; sign/zero extension is done by the LSU.
REQ-017 mem_req_valid / mem_req_ready  output / input  1 / 1  request handshake to the shared memory port.
REQ-018 mem_addr / mem_wen / mem_wdata / mem_len  output  32 / 1 / 32 / 3  latched request fields.
REQ-019 mem_resp_valid / mem_rdata  input  1 / 32  memory response.
REQ-020 arb_owner  output  2  current owner: 00 none, 01 IFU, 10 LSU.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE and WAIT; exactly one transaction is outstanding at a time.
REQ-022 IDLE, any request valid: arbitrate, latch the winner's fields into the mem_* registers, pulse the winner's req_ready, set arb_owner, and go to ISSUE.
REQ-023 Field latching SHALL follow these rules:
- IFU grant: mem_wen=0, mem_len=4, mem_wdata=0.
- LSU grant: fields copied from the lsu_* inputs.
REQ-024 ISSUE: mem_req_valid=1 with the latched fields held stable; on mem_req_ready=1 go to WAIT.
REQ-025 WAIT: on mem_resp_valid=1, in the same cycle, drive the owner's resp_valid=1 and rdata=mem_rdata (combinational), then go to IDLE with arb_owner=00.
REQ-026 Non-owner resp_valid SHALL be 0; non-owner rdata SHALL be 0.
REQ-027 mem_resp_valid outside WAIT SHALL be ignored.
REQ-028 mem_req_ready outside ISSUE SHALL be ignored.
REQ-029 A requester dropping req_valid after acceptance SHALL NOT affect the transaction.
REQ-030 Minimum latency SHALL be:
- accept at cycle 0;
- mem_req_valid at cycle 1;
- resp_valid at cycle 2 (mem_req_ready and mem_resp_valid both at earliest).
REQ-031 The IDLE cycle following a response SHALL accept a new request; back-to-back throughput is one transaction per 3 cycles minimum.
REQ-032 Both valid in the same IDLE cycle: the winner is chosen per REQ-038/REQ-039; the loser waits, its req_ready stays 0.

Reset
REQ-033 On rst=1 the FSM SHALL go to IDLE and all outputs SHALL be 0, including:
- arb_owner=00;
- mem_req_valid=0;
- mem_addr, mem_wdata, mem_len, mem_wen = 0;
- all ready and resp_valid outputs = 0.
REQ-034 Reset in ISSUE or WAIT SHALL abort the transaction with no response pulse; a later mem_resp_valid is dropped per REQ-027.
REQ-035 The round-robin pointer SHALL reset to "last granted = IFU".

Configuration
REQ-036 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-037 Only arbitration with both requests valid is affected by ARB_ROUND_ROBIN_EN.
REQ-038 ARB_ROUND_ROBIN_EN defined: grant the requester not granted last. The pointer updates on each grant, so the first contention after reset goes to the LSU.
REQ-039 ARB_ROUND_ROBIN_EN undefined: the LSU always wins contention, and no pointer register exists.

Verification
REQ-040 IFU-only read, mem_req_ready=1 and mem_resp_valid=1 immediately, addr=0x80000000, mem_rdata=0x00000413 -> ifu_req_ready at cycle 0, mem_req_valid at cycle 1, ifu_resp_valid=1 with ifu_rdata=0x00000413 at cycle 2.
REQ-041 LSU store addr=0x80001000, wdata=0xDEADBEEF, len=1 -> mem_wen=1, mem_len=1, mem_wdata=0xDEADBEEF held through a 3-cycle mem_req_ready stall; lsu_resp_valid pulses once.
REQ-042 Both valid continuously, four transactions:
- undefined ARB_ROUND_ROBIN_EN: owners LSU, LSU, LSU, LSU;
- defined ARB_ROUND_ROBIN_EN: owners LSU, IFU, LSU, IFU.
REQ-043 rst=1 asserted in WAIT, then mem_resp_valid=1 one cycle after rst deasserts -> no resp_valid pulse, arb_owner=00, FSM in IDLE.
REQ-044 Spurious mem_resp_valid=1 in IDLE with mem_rdata=0x12345678 -> ifu_resp_valid=0, lsu_resp_valid=0, both rdata outputs 0.
